req_pending_latch: RTL and testbench

- Upstream stage of the 8-to-3 MSB-priority encoder.
- Detects rising edges on 8 request lines and holds each one as a sticky pending bit.
- Drives the masked pending vector into the encoder's 8-bit input.
- Clears a pending bit when the consumer acknowledges it with the 3-bit code the encoder produced. Counts requests lost because the line was already pending.

---
 rtl/req_pending_latch.sv | 179 +++++++++++++++++
 tb/tb_req_pending_latch.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/req_pending_latch.sv
`default_nettype none
// ============================================================================
// Module      : req_pending_latch
// Description : Upstream stage of the 8-to-3 MSB-priority encoder. Detects
//               rising edges on eight request lines, holds each event as a
//               sticky pending bit, presents the masked pending vector to the
//               encoder, clears bits on acknowledge (by encoder code) and
//               counts events lost because their line was already pending.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   CNT_W       width of the saturating drop counter (default 8)
// Ports
//   clk         system clock, all logic on the rising edge
//   rst         synchronous, active-high reset
//   req_i[7:0]  request lines; a rising edge is a new event
//   mask_i[7:0] per-line visibility on pend_o / any_o (1 = visible)
//   ack_i       acknowledge strobe, one cycle per ack
//   ack_code_i  encoder code being acked; targets line 7 - ack_code_i
//   clr_i       global clear of pending bits, error flag and counter
//   pend_o[7:0] registered pending & mask_i; drives the encoder input
//   any_o       registered OR of pend_o
//   drop_cnt_o  saturating count of dropped events
//   ack_err_o   sticky flag: an ack targeted a non-pending line
// Build option
//   REQ_SYNC_EN defined  : req_i passes a 2-flop synchronizer before edge
//                          detection (event-to-pend_o latency 3 edges).
//   REQ_SYNC_EN undefined: req_i is used directly (latency 1 edge) and must
//                          be synchronous to clk.
// ============================================================================

module req_pending_latch #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       req_i,
    input  logic [7:0]       mask_i,
    input  logic             ack_i,
    input  logic [2:0]       ack_code_i,
    input  logic             clr_i,
    output logic [7:0]       pend_o,
    output logic             any_o,
    output logic [CNT_W-1:0] drop_cnt_o,
    output logic             ack_err_o
);

    // Sum is wide enough to hold the counter maximum plus eight drops.
    localparam int              SUM_W   = CNT_W + 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // ------------------------------------------------------------------------
    // Request conditioning
    // ------------------------------------------------------------------------
    logic [7:0] req_s;

`ifdef REQ_SYNC_EN
    logic [7:0] sync1_q, sync1_d;
    logic [7:0] sync2_q, sync2_d;

    always_comb begin
        sync1_d = req_i;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 8'h00;
            sync2_q <= 8'h00;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign req_s = sync2_q;
`else
    assign req_s = req_i;
`endif

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [7:0]       req_q,      req_d;
    logic [7:0]       pending_q,  pending_d;
    logic [7:0]       pend_q,     pend_d;
    logic             any_q,      any_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic             ack_err_q,  ack_err_d;

    // ------------------------------------------------------------------------
    // Event, ack and drop decode
    // ------------------------------------------------------------------------
    logic [7:0]       rise;
    logic [2:0]       ack_line;
    logic [7:0]       ack_vec;
    logic             ack_miss;
    logic [7:0]       drop;
    logic [3:0]       drop_pop;
    logic [SUM_W-1:0] cnt_sum;

    always_comb begin
        rise = req_s & ~req_q;

        // Encoder code 0 means the highest line, so the line index is inverted.
        ack_line = 3'd7 - ack_code_i;
        ack_vec  = ack_i ? (8'b0000_0001 << ack_line) : 8'h00;
        ack_miss = ack_i & ~pending_q[ack_line];

        // A rise that coincides with an ack of the same line re-arms the bit
        // instead of being counted as lost.
        drop = rise & pending_q & ~ack_vec;

        drop_pop = 4'd0;
        for (int i = 0; i < 8; i++) begin
            drop_pop = drop_pop + {3'b000, drop[i]};
        end

        cnt_sum = {{4{1'b0}}, drop_cnt_q} + {{CNT_W{1'b0}}, drop_pop};
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        // The edge detector tracks the input even through a clear, so lines
        // that stay high across clr_i do not generate a fresh event.
        req_d = req_s;

        if (clr_i) begin
            pending_d  = 8'h00;
            drop_cnt_d = '0;
            ack_err_d  = 1'b0;
        end else begin
            pending_d = (pending_q & ~ack_vec) | rise;

            if (cnt_sum > {{4{1'b0}}, CNT_MAX}) begin
                drop_cnt_d = CNT_MAX;
            end else begin
                drop_cnt_d = cnt_sum[CNT_W-1:0];
            end

            ack_err_d = ack_err_q | ack_miss;
        end

        // Mask only gates what the encoder sees; held bits stay latched.
        pend_d = pending_d & mask_i;
        any_d  = |pend_d;
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q      <= 8'h00;
            pending_q  <= 8'h00;
            pend_q     <= 8'h00;
            any_q      <= 1'b0;
            drop_cnt_q <= '0;
            ack_err_q  <= 1'b0;
        end else begin
            req_q      <= req_d;
            pending_q  <= pending_d;
            pend_q     <= pend_d;
            any_q      <= any_d;
            drop_cnt_q <= drop_cnt_d;
            ack_err_q  <= ack_err_d;
        end
    end

    assign pend_o     = pend_q;
    assign any_o      = any_q;
    assign drop_cnt_o = drop_cnt_q;
    assign ack_err_o  = ack_err_q;

endmodule

`default_nettype wire

// File: tb/tb_req_pending_latch.sv
`default_nettype none
// ============================================================================
// Module      : tb_req_pending_latch
// Description : Self-checking bench for req_pending_latch. Directed steps
//               followed by randomized traffic, all checked every cycle
//               against a per-line behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_req_pending_latch;

    localparam int CNT_W = 2;
    localparam int MAXC  = (1 << CNT_W) - 1;
`ifdef REQ_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [7:0]       req_i = 8'h00;
    logic [7:0]       mask_i = 8'hFF;
    logic             ack_i = 1'b0;
    logic [2:0]       ack_code_i = 3'd0;
    logic             clr_i = 1'b0;
    logic [7:0]       pend_o;
    logic             any_o;
    logic [CNT_W-1:0] drop_cnt_o;
    logic             ack_err_o;

    int total = 0;
    int bad   = 0;

    // Reference model state (one entry per request line)
    bit       m_pend [8];
    bit       m_prev [8];
    int       m_cnt;
    bit       m_err;
    bit [7:0] m_vis;
    bit [7:0] m_s1, m_s2;

    req_pending_latch #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req_i),
        .mask_i     (mask_i),
        .ack_i      (ack_i),
        .ack_code_i (ack_code_i),
        .clr_i      (clr_i),
        .pend_o     (pend_o),
        .any_o      (any_o),
        .drop_cnt_o (drop_cnt_o),
        .ack_err_o  (ack_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Applies the event rules to the inputs present at this clock edge.
    task automatic model_edge();
        bit [7:0] eff;
        int       tgt;
        int       drops;
        bit       rise;
        bit       acked;
`ifdef REQ_SYNC_EN
        eff = m_s2;
`else
        eff = req_i;
`endif
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                m_pend[i] = 0;
                m_prev[i] = 0;
            end
            m_cnt = 0;
            m_err = 0;
            m_s1  = 8'h00;
            m_s2  = 8'h00;
        end else begin
            m_s2 = m_s1;
            m_s1 = req_i;
            if (clr_i) begin
                for (int i = 0; i < 8; i++) m_pend[i] = 0;
                m_cnt = 0;
                m_err = 0;
            end else begin
                tgt   = 7 - int'(ack_code_i);
                drops = 0;
                if (ack_i && !m_pend[tgt]) m_err = 1;
                for (int i = 0; i < 8; i++) begin
                    rise  = eff[i] && !m_prev[i];
                    acked = ack_i && (i == tgt);
                    if (rise) begin
                        if (m_pend[i] && !acked) drops++;
                        m_pend[i] = 1;
                    end else if (acked) begin
                        m_pend[i] = 0;
                    end
                end
                m_cnt = (m_cnt + drops > MAXC) ? MAXC : m_cnt + drops;
            end
            for (int i = 0; i < 8; i++) m_prev[i] = eff[i];
        end
        for (int i = 0; i < 8; i++) m_vis[i] = m_pend[i] && mask_i[i];
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        chk("pend_o", pend_o, m_vis);
        chk("any_o", any_o, |m_vis);
        chk("drop_cnt_o", drop_cnt_o, m_cnt);
        chk("ack_err_o", ack_err_o, m_err);
    endtask

    task automatic hold(input int n);
        repeat (n) cyc();
    endtask

    task automatic ack_once(input logic [2:0] code);
        ack_i = 1'b1;
        ack_code_i = code;
        cyc();
        ack_i = 1'b0;
    endtask

    initial begin
        int line;
        m_cnt = 0;
        m_err = 0;
        m_vis = 8'h00;
        m_s1  = 8'h00;
        m_s2  = 8'h00;
        for (int i = 0; i < 8; i++) begin
            m_pend[i] = 0;
            m_prev[i] = 0;
        end

        // Reset state
        rst = 1'b1;
        hold(2);
        chk("reset pend_o", pend_o, 8'h00);
        chk("reset any_o", any_o, 1'b0);
        chk("reset drop_cnt_o", drop_cnt_o, 0);
        chk("reset ack_err_o", ack_err_o, 1'b0);
        rst = 1'b0;

        // Single edge, then ack by encoder code
        hold(3);
        req_i = 8'h04;
        hold(LAT);
        chk("single edge pend_o", pend_o, 8'h04);
        chk("single edge any_o", any_o, 1'b1);
        ack_once(3'b101);
        chk("ack clears pend_o", pend_o, 8'h00);

        // Held level gives one event; re-raise without ack is a drop
        req_i = 8'h80;
        hold(6);
        chk("held level pend_o", pend_o, 8'h80);
        chk("held level drop_cnt_o", drop_cnt_o, 0);
        req_i = 8'h00;
        hold(3);
        req_i = 8'h80;
        hold(3);
        chk("re-raise drop_cnt_o", drop_cnt_o, 1);
        chk("re-raise pend_o", pend_o, 8'h80);
        req_i = 8'h01;
        hold(3);
        req_i = 8'h00;
        hold(3);
        req_i = 8'h81;
        hold(3);
        chk("double drop saturates", drop_cnt_o, 3);
        req_i = 8'h00;
        hold(3);
        req_i = 8'h81;
        hold(3);
        chk("drop_cnt_o saturated", drop_cnt_o, 3);

        // Clear; lines held high do not re-fire
        clr_i = 1'b1;
        cyc();
        clr_i = 1'b0;
        chk("clr drop_cnt_o", drop_cnt_o, 0);
        chk("clr pend_o", pend_o, 8'h00);
        hold(3);
        chk("no re-fire after clr", pend_o, 8'h00);

        // Simultaneous rise and ack on line 4
        req_i = 8'h00;
        hold(3);
        req_i = 8'h10;
        hold(3);
        req_i = 8'h00;
        hold(3);
        req_i = 8'h10;
        hold(LAT - 1);
        ack_once(3'b011);
        chk("set wins pend_o", pend_o, 8'h10);
        chk("set wins drop_cnt_o", drop_cnt_o, 0);

        // Mask and ack error
        clr_i = 1'b1;
        cyc();
        clr_i = 1'b0;
        req_i = 8'h00;
        hold(3);
        mask_i = 8'h0F;
        req_i = 8'h30;
        hold(3);
        chk("masked pend_o", pend_o, 8'h00);
        chk("masked any_o", any_o, 1'b0);
        mask_i = 8'hFF;
        cyc();
        chk("unmasked pend_o", pend_o, 8'h30);
        ack_once(3'b000);
        chk("ack_err_o set", ack_err_o, 1'b1);
        chk("bad ack pend_o", pend_o, 8'h30);
        hold(2);
        chk("ack_err_o sticky", ack_err_o, 1'b1);

        // Reset mid-operation with a line still high
        req_i = 8'h00;
        hold(3);
        req_i = 8'hFF;
        hold(3);
        chk("all pending", pend_o, 8'hFF);
        req_i = 8'h01;
        hold(3);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("mid reset pend_o", pend_o, 8'h00);
        chk("mid reset ack_err_o", ack_err_o, 1'b0);
        hold(LAT - 1);
        chk("before re-fire", pend_o, 8'h00);
        cyc();
        chk("re-fire after reset", pend_o, 8'h01);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            rst   = ($urandom_range(0, 79) == 0);
            clr_i = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 3) == 0) req_i = req_i ^ 8'($urandom_range(0, 255) & $urandom_range(0, 255));
            if ($urandom_range(0, 15) == 0) mask_i = 8'($urandom_range(0, 255));
            ack_i = ($urandom_range(0, 2) == 0);
            ack_code_i = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) begin
                for (int t = 0; t < 8; t++) begin
                    line = $urandom_range(0, 7);
                    if (m_pend[line]) begin
                        ack_code_i = 3'(7 - line);
                        break;
                    end
                end
            end
            cyc();
        end
        rst = 1'b0;
        clr_i = 1'b0;
        ack_i = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
